// File: rtl/ntt_host_port.sv
// Host streaming front end for the wide NTT core: packs coefficients into rows, runs the core, unloads rows.
// Optional macro NTT_HOST_PERF_CNT_EN builds the start-to-done cycle counter driven on perf_cycles.
module ntt_host_port #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 257,
    parameter int ROWS    = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [5:0]              cmd_mod_idx,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy,
    output logic                    ntt_start,
    output logic [5:0]              ntt_mod_idx,
    input  logic                    ntt_done,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [8*SIZE-1:0]       mem_addr,
    output logic [WIDTH*SIZE-1:0]   mem_din,
    input  logic [WIDTH*SIZE-1:0]   mem_dout,
    output logic [31:0]             perf_cycles
);
    localparam int LW = (SIZE > 1) ? $clog2(SIZE) + 1 : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(SIZE - 1);
    localparam logic [7:0]    ROW_LAST  = 8'(ROWS - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, START, BUSY, RD_REQ, RD_WAIT, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [LW-1:0]         lane_reg;
    logic [7:0]            row_reg;
    logic [7:0]            wait_reg;
    logic [1:0]            hold_reg;
    logic                  cmd_ready_reg;
    logic [5:0]            mod_idx_reg;
    logic [WIDTH-1:0]      m_data_reg;
    logic [WIDTH*SIZE-1:0] buf_flat;
    logic [LW-1:0]         lane_inc;
    logic                  cmd_fire, s_fire, m_fire, done_ok, capture;

    assign cmd_fire = cmd_valid & cmd_ready_reg;
    assign s_fire   = s_valid & (state_reg == LOAD);
    assign m_fire   = m_ready & (state_reg == DRAIN);
    // the core's done level may still be high from the previous job for two cycles
    assign done_ok  = (state_reg == BUSY) && (hold_reg == 2'd2) && ntt_done;
    assign capture  = ((state_reg == RD_REQ) && (MEM_LAT == 0)) ||
                      ((state_reg == RD_WAIT) && (wait_reg == WAIT_LAST));
    assign lane_inc = lane_reg + 1'b1;

    // One row buffer serves both directions: load and unload never overlap in time.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        logic [WIDTH-1:0] slot_reg;
        always_ff @(posedge clk) begin
            if (capture)
                slot_reg <= mem_dout[gi*WIDTH +: WIDTH];
            else if (s_fire && (lane_reg == LW'(gi)))
                slot_reg <= s_data;
        end
        assign buf_flat[gi*WIDTH +: WIDTH] = slot_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            lane_reg      <= '0;
            row_reg       <= '0;
            wait_reg      <= '0;
            hold_reg      <= '0;
            cmd_ready_reg <= 1'b0;
            mod_idx_reg   <= '0;
            m_data_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: if (cmd_fire) begin
                    mod_idx_reg <= cmd_mod_idx;
                    row_reg     <= '0;
                    lane_reg    <= '0;
                end
                LOAD: if (s_fire) lane_reg <= lane_inc;
                WRITE: if (row_reg != ROW_LAST) begin
                    row_reg  <= row_reg + 8'd1;
                    lane_reg <= '0;
                end
                START: hold_reg <= '0;
                BUSY: begin
                    if (hold_reg != 2'd2) hold_reg <= hold_reg + 2'd1;
                    if (done_ok) row_reg <= '0;
                end
                RD_REQ:  wait_reg <= '0;
                RD_WAIT: wait_reg <= wait_reg + 8'd1;
                DRAIN: if (m_fire) begin
                    if (lane_reg == LANE_LAST) begin
                        lane_reg <= '0;
                        if (row_reg != ROW_LAST) row_reg <= row_reg + 8'd1;
                    end else begin
                        lane_reg   <= lane_inc;
                        m_data_reg <= buf_flat[lane_inc*WIDTH +: WIDTH];
                    end
                end
                default: ;
            endcase
            if (capture) begin
                lane_reg   <= '0;
                m_data_reg <= mem_dout[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire) state_next = LOAD;
            LOAD:    if (s_fire && (lane_reg == LANE_LAST)) state_next = WRITE;
            WRITE:   state_next = (row_reg == ROW_LAST) ? START : LOAD;
            START:   state_next = BUSY;
            BUSY:    if (done_ok) state_next = RD_REQ;
            RD_REQ:  state_next = capture ? DRAIN : RD_WAIT;
            RD_WAIT: if (capture) state_next = DRAIN;
            DRAIN:   if (m_fire && (lane_reg == LANE_LAST))
                         state_next = (row_reg == ROW_LAST) ? IDLE : RD_REQ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        busy      = 1'b1;
        ntt_start = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        case (state_reg)
            IDLE:            busy = 1'b0;
            LOAD:            s_ready = 1'b1;
            WRITE:           mem_write = 1'b1;
            START:           ntt_start = 1'b1;
            RD_REQ, RD_WAIT: mem_read = 1'b1;
            DRAIN: begin
                m_valid = 1'b1;
                m_last  = (lane_reg == LANE_LAST) && (row_reg == ROW_LAST);
            end
            default: ;
        endcase
    end

    assign mem_addr    = (mem_write | mem_read) ? {SIZE{row_reg}} : '0;
    assign mem_din     = mem_write ? buf_flat : '0;
    assign cmd_ready   = cmd_ready_reg;
    assign m_data      = m_data_reg;
    assign ntt_mod_idx = mod_idx_reg;

`ifdef NTT_HOST_PERF_CNT_EN
    logic [31:0] perf_reg;
    always_ff @(posedge clk) begin
        if (!reset)
            perf_reg <= '0;
        else if (state_reg == START)
            perf_reg <= '0;
        else if (state_reg == BUSY)
            perf_reg <= perf_reg + 32'd1;
    end
    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif
endmodule
